controle_multiciclo: RTL and testbench

// Multi-cycle main control FSM for the MIPS datapath. It replaces the single-cycle opcode decoder
// by sequencing each instruction over 3-5 states: fetch, decode, execute, memory and write-back.
// It drives the shared memory, IR, PC, ALU-source and register-file enables, and supports wait

---
 rtl/controle_multiciclo.sv | 169 ++++++++++++++++
 tb/tb_controle_multiciclo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle main control FSM for the MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, with memory wait states through MemPronta.
module controle_multiciclo #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_ADDI  = 6'b001000,
   parameter logic [5:0] OP_J     = 6'b000010
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       MemPronta,
   output logic       IouD,
   output logic       LeMem,
   output logic       EscreveMem,
   output logic       EscreveIR,
   output logic       EscrevePC,
   output logic       EscrevePCCond,
   output logic [1:0] OrigPC,
   output logic       OrigALUA,
   output logic [1:0] OrigALUB,
   output logic [1:0] OpALU,
   output logic       RegDst,
   output logic       MemparaReg,
   output logic       EscreveReg,
   output logic       InstrFim,
   output logic       InstrInvalida,
   output logic [3:0] estado
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   state_t r_estado;
   state_t w_prox;
   logic   w_op_valido;

   assign w_op_valido = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                        (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);
   assign estado = r_estado;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estado <= S_IDLE;
      else        r_estado <= w_prox;
   end

   always_comb begin
      w_prox = S_FETCH;
      case (r_estado)
         S_IDLE:   w_prox = S_FETCH;
         S_FETCH:  w_prox = MemPronta ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW) w_prox = S_MEMADR;
            else if (opcode == OP_RTYPE)            w_prox = S_EXEC;
            else if (opcode == OP_BEQ)              w_prox = S_BRANCH;
            else if (opcode == OP_ADDI)             w_prox = S_ADDIEX;
            else if (opcode == OP_J)                w_prox = S_JUMP;
            else                                    w_prox = S_FETCH;
         end
         S_MEMADR: w_prox = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  w_prox = MemPronta ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_prox = S_FETCH;
         S_MEMWR:  w_prox = MemPronta ? S_FETCH : S_MEMWR;
         S_EXEC:   w_prox = S_ALUWB;
         S_ALUWB:  w_prox = S_FETCH;
         S_BRANCH: w_prox = S_FETCH;
         S_ADDIEX: w_prox = S_ADDIWB;
         S_ADDIWB: w_prox = S_FETCH;
         S_JUMP:   w_prox = S_FETCH;
         default:  w_prox = S_FETCH;
      endcase
   end

   // Decoded combinationally from state: MemPronta must qualify FETCH/MEMWR in the same cycle,
   // and the async reset forces IDLE, so every output drops as soon as rst_n falls.
   always_comb begin
      IouD          = 1'b0;
      LeMem         = 1'b0;
      EscreveMem    = 1'b0;
      EscreveIR     = 1'b0;
      EscrevePC     = 1'b0;
      EscrevePCCond = 1'b0;
      OrigPC        = 2'b00;
      OrigALUA      = 1'b0;
      OrigALUB      = 2'b00;
      OpALU         = 2'b00;
      RegDst        = 1'b0;
      MemparaReg    = 1'b0;
      EscreveReg    = 1'b0;
      InstrFim      = 1'b0;
      InstrInvalida = 1'b0;
      case (r_estado)
         S_FETCH: begin
            LeMem     = 1'b1;
            OrigALUB  = 2'b01;
            EscreveIR = MemPronta;
            EscrevePC = MemPronta;
         end
         S_DECODE: begin
            OrigALUB      = 2'b11;
            InstrInvalida = ~w_op_valido;
         end
         S_MEMADR: begin
            OrigALUA = 1'b1;
            OrigALUB = 2'b10;
         end
         S_MEMRD: begin
            LeMem = 1'b1;
            IouD  = 1'b1;
         end
         S_MEMWB: begin
            MemparaReg = 1'b1;
            EscreveReg = 1'b1;
            InstrFim   = 1'b1;
         end
         S_MEMWR: begin
            EscreveMem = 1'b1;
            IouD       = 1'b1;
            InstrFim   = MemPronta;
         end
         S_EXEC: begin
            OrigALUA = 1'b1;
            OpALU    = 2'b10;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            EscreveReg = 1'b1;
            InstrFim   = 1'b1;
         end
         S_BRANCH: begin
            OrigALUA      = 1'b1;
            OpALU         = 2'b01;
            EscrevePCCond = 1'b1;
            OrigPC        = 2'b01;
            InstrFim      = 1'b1;
         end
         S_ADDIEX: begin
            OrigALUA = 1'b1;
            OrigALUB = 2'b10;
         end
         S_ADDIWB: begin
            EscreveReg = 1'b1;
            InstrFim   = 1'b1;
         end
         S_JUMP: begin
            EscrevePC = 1'b1;
            OrigPC    = 2'b10;
            InstrFim  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle expectations from an instruction-path
// reference model are queued by the stimulus and checked by an independent monitor.
module tb_controle_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       MemPronta;
   logic       IouD, LeMem, EscreveMem, EscreveIR, EscrevePC, EscrevePCCond;
   logic [1:0] OrigPC, OrigALUB, OpALU;
   logic       OrigALUA, RegDst, MemparaReg, EscreveReg, InstrFim, InstrInvalida;
   logic [3:0] estado;

   controle_multiciclo dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .MemPronta(MemPronta),
      .IouD(IouD), .LeMem(LeMem), .EscreveMem(EscreveMem), .EscreveIR(EscreveIR),
      .EscrevePC(EscrevePC), .EscrevePCCond(EscrevePCCond), .OrigPC(OrigPC),
      .OrigALUA(OrigALUA), .OrigALUB(OrigALUB), .OpALU(OpALU), .RegDst(RegDst),
      .MemparaReg(MemparaReg), .EscreveReg(EscreveReg), .InstrFim(InstrFim),
      .InstrInvalida(InstrInvalida), .estado(estado)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       IouD, LeMem, EscreveMem, EscreveIR, EscrevePC, EscrevePCCond;
      logic [1:0] OrigPC;
      logic       OrigALUA;
      logic [1:0] OrigALUB, OpALU;
      logic       RegDst, MemparaReg, EscreveReg, InstrFim, InstrInvalida;
   } outs_t;

   typedef struct {
      logic [3:0] st;
      outs_t      o;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0, n_bad = 0, n_push = 0, cur_tag = 0;
   event smp_ev;

   function automatic bit op_ok(logic [5:0] op);
      return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
   endfunction

   // What the datapath must see in a given step of an instruction.
   function automatic outs_t ref_outs(int st, bit mp, logic [5:0] op);
      outs_t o = '0;
      case (st)
         1:  begin o.LeMem = 1; o.OrigALUB = 2'b01; o.EscreveIR = mp; o.EscrevePC = mp; end
         2:  begin o.OrigALUB = 2'b11; o.InstrInvalida = !op_ok(op); end
         3:  begin o.OrigALUA = 1; o.OrigALUB = 2'b10; end
         4:  begin o.LeMem = 1; o.IouD = 1; end
         5:  begin o.MemparaReg = 1; o.EscreveReg = 1; o.InstrFim = 1; end
         6:  begin o.EscreveMem = 1; o.IouD = 1; o.InstrFim = mp; end
         7:  begin o.OrigALUA = 1; o.OpALU = 2'b10; end
         8:  begin o.RegDst = 1; o.EscreveReg = 1; o.InstrFim = 1; end
         9:  begin o.OrigALUA = 1; o.OpALU = 2'b01; o.EscrevePCCond = 1; o.OrigPC = 2'b01;
                   o.InstrFim = 1; end
         10: begin o.OrigALUA = 1; o.OrigALUB = 2'b10; end
         11: begin o.EscreveReg = 1; o.InstrFim = 1; end
         12: begin o.EscrevePC = 1; o.OrigPC = 2'b10; o.InstrFim = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic push(int st, bit mp, logic [5:0] op);
      exp_t e;
      e.st = st[3:0]; e.o = ref_outs(st, mp, op); e.tag = cur_tag;
      q.push_back(e);
      n_push++;
   endtask

   // One clock cycle: drive, record expectation, advance to just after the next edge.
   task automatic cyc(int st, bit mp, logic [5:0] op);
      MemPronta = mp; opcode = op;
      push(st, mp, op);
      @(posedge clk); #1;
   endtask

   task automatic run_instr(logic [5:0] op, int wf, int wm);
      cur_tag++;
      for (int w = 0; w <= wf; w++) cyc(1, w == wf, 6'($urandom));
      cyc(2, 1'($urandom), op);
      case (op)
         6'h00: begin cyc(7, 1'($urandom), op); cyc(8, 1'($urandom), op); end
         6'h23: begin
            cyc(3, 1'($urandom), op);
            for (int w = 0; w <= wm; w++) cyc(4, w == wm, op);
            cyc(5, 1'($urandom), op);
         end
         6'h2B: begin
            cyc(3, 1'($urandom), op);
            for (int w = 0; w <= wm; w++) cyc(6, w == wm, op);
         end
         6'h04: cyc(9, 1'($urandom), op);
         6'h08: begin cyc(10, 1'($urandom), op); cyc(11, 1'($urandom), op); end
         6'h02: cyc(12, 1'($urandom), op);
         default: ;
      endcase
   endtask

   initial begin : monitor
      exp_t  e;
      outs_t a;
      forever begin
         @(negedge clk or smp_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{IouD, LeMem, EscreveMem, EscreveIR, EscrevePC, EscrevePCCond, OrigPC,
                  OrigALUA, OrigALUB, OpALU, RegDst, MemparaReg, EscreveReg, InstrFim,
                  InstrInvalida};
            n_cmp++;
            if (estado !== e.st || a !== e.o) begin
               n_bad++;
               $display("FAIL instr%0d t=%0t: estado=%0d outs=%b, expected estado=%0d outs=%b",
                        e.tag, $time, estado, a, e.st, e.o);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   logic [5:0] ops[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};

   initial begin : stim
      rst_n = 1'b0; opcode = 6'h00; MemPronta = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push(0, 0, 6'h00);      // reset state observed in IDLE
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_instr(6'h00, 0, 0); // R-type: 1,2,7,8
      run_instr(6'h23, 0, 2); // lw with two wait cycles in MEMRD
      run_instr(6'h00, 3, 0); // three FETCH wait states
      run_instr(6'h04, 0, 0);
      run_instr(6'h02, 0, 0);
      run_instr(6'h3F, 0, 0); // unsupported, skipped
      run_instr(6'h2B, 0, 0);
      run_instr(6'h08, 1, 0);
      run_instr(6'h2B, 0, 3);

      // Reset while a store is stalled in MEMWR with EscreveMem high.
      cur_tag++;
      cyc(1, 1, 6'h2B); cyc(2, 1, 6'h2B); cyc(3, 1, 6'h2B);
      MemPronta = 1'b0;
      push(6, 0, 6'h2B);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      push(0, 0, 6'h2B);
      ->smp_ev;
      @(posedge clk); #1;
      push(0, 0, 6'h2B);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_instr(6'h00, 0, 0); // FETCH one cycle after release

      for (int i = 0; i < 60; i++)
         run_instr(ops[$urandom_range(7)], $urandom_range(2), $urandom_range(3));

      @(negedge clk); #1;
      n_cmp++;
      if (q.size() != 0 || n_cmp != n_push + 1) begin
         n_bad++;
         $display("FAIL drain: %0d checked of %0d queued, %0d left", n_cmp - 1, n_push, q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
